// File: rtl/bram_stream_reader_pkg.sv
// Shared types and helpers for the block-RAM stream reader.
package bram_stream_reader_pkg;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  localparam int DEF_RAM_WIDTH = 18;
  localparam int DEF_RAM_DEPTH = 1024;
  localparam int DEF_ADDR_W    = clog2(DEF_RAM_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/bram_stream_reader_if.sv
// RAM read port plus output stream, bundled; master is the reader side.
interface bram_stream_reader_if #(
  parameter int RAM_WIDTH = 18,
  parameter int ADDR_W    = 10
);
  logic [ADDR_W-1:0]    ram_addr_out;
  logic                 ram_en_out;
  logic                 ram_regce_out;
  logic [RAM_WIDTH-1:0] ram_data_in;
  logic [RAM_WIDTH-1:0] data_out;
  logic                 valid_out;
  logic                 last_out;
  logic                 ready_in;

  modport master (
    output ram_addr_out, ram_en_out, ram_regce_out, data_out, valid_out, last_out,
    input  ram_data_in, ready_in
  );

  modport slave (
    input  ram_addr_out, ram_en_out, ram_regce_out, data_out, valid_out, last_out,
    output ram_data_in, ready_in
  );
endinterface

// File: rtl/bram_stream_reader_stream_fifo.sv
// Small synchronous FIFO; head entry is read combinationally from storage.
module stream_fifo
  import bram_stream_reader_pkg::*;
#(
  parameter int  WIDTH = 19,
  parameter int  DEPTH = 4,
  localparam int PW    = clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             do_pop;

  assign do_pop = pop && (count != '0);
  assign dout   = mem_q[rd_ptr];

  // Storage is cleared too so the stream data reads 0 out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr] <= din;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/bram_stream_reader.sv
// Issues sequential RAM reads and streams the words out; credits cover the RAM latency.
module bram_stream_reader
  import bram_stream_reader_pkg::*;
#(
  parameter int  RAM_WIDTH    = 18,
  parameter int  RAM_DEPTH    = 1024,
  parameter int  READ_LATENCY = 2,
  parameter int  FIFO_DEPTH   = 4,
  localparam int ADDR_W       = clog2(RAM_DEPTH)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start_in,
  input  logic [ADDR_W-1:0] base_addr_in,
  input  logic [ADDR_W:0]   len_in,
  output logic              busy_out,
  output logic              done_out,
  bram_stream_reader_if.master bus
);
  localparam int CW = clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W:0] LEN_ONE = 1;

  state_t                  state_q, state_d;
  logic [ADDR_W-1:0]       addr_q;
  logic [ADDR_W:0]         len_q, issued_q;
  logic [READ_LATENCY-1:0] vld_pipe, last_pipe;
  logic [CW-1:0]           fifo_count;
  logic [RAM_WIDTH:0]      fifo_head;
  logic                    ram_en, is_last_issue, credit_ok, valid, pop;
  int                      inflight;

  always_comb begin
    inflight = 0;
    for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + int'(vld_pipe[i]);
  end

  // A pop this cycle is only credited once fifo_count reflects it next cycle.
  assign credit_ok     = (int'(fifo_count) + inflight) < FIFO_DEPTH;
  assign is_last_issue = (issued_q == len_q - LEN_ONE);
  assign ram_en        = (state_q == S_READ) && (issued_q < len_q) && credit_ok;
  assign valid         = (fifo_count != '0);
  assign pop           = valid && bus.ready_in;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_in) state_d = (len_in == '0) ? S_DONE : S_READ;
      S_READ:  if (ram_en && is_last_issue) state_d = S_DRAIN;
      S_DRAIN: if (pop && fifo_head[RAM_WIDTH]) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      issued_q  <= '0;
      vld_pipe  <= '0;
      last_pipe <= '0;
    end else begin
      state_q      <= state_d;
      vld_pipe[0]  <= ram_en;
      last_pipe[0] <= ram_en && is_last_issue;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        last_pipe[i] <= last_pipe[i-1];
      end
      case (state_q)
        S_IDLE: if (start_in) begin
          addr_q   <= base_addr_in;
          len_q    <= len_in;
          issued_q <= '0;
        end
        S_READ: if (ram_en) begin
          issued_q <= issued_q + LEN_ONE;
          addr_q   <= (addr_q == ADDR_W'(RAM_DEPTH - 1)) ? '0 : addr_q + 1'b1;
        end
        S_DONE: begin
          addr_q   <= '0;
          len_q    <= '0;
          issued_q <= '0;
        end
        default: ;
      endcase
    end
  end

  stream_fifo #(.WIDTH(RAM_WIDTH + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk_in),
    .rst   (rst_in),
    .push  (vld_pipe[READ_LATENCY-1]),
    .din   ({last_pipe[READ_LATENCY-1], bus.ram_data_in}),
    .pop   (pop),
    .dout  (fifo_head),
    .count (fifo_count)
  );

  assign bus.ram_addr_out  = addr_q;
  assign bus.ram_en_out    = ram_en;
  assign bus.ram_regce_out = 1'b1;
  assign bus.data_out      = fifo_head[RAM_WIDTH-1:0];
  assign bus.last_out      = fifo_head[RAM_WIDTH];
  assign bus.valid_out     = valid;
  assign busy_out          = (state_q != S_IDLE);
  assign done_out          = (state_q == S_DONE);
endmodule

// File: tb/tb_bram_stream_reader.sv
// Bench: latency-2 RAM model, scoreboard queues for addresses and stream words.
module tb_bram_stream_reader;
  localparam int W = 18, DEPTH = 1024, AW = 10, LIMIT = 4000;

  logic clk = 0, rst = 1, start = 0;
  logic [AW-1:0] base = '0;
  logic [AW:0]   len = '0;
  logic busy, done;

  bram_stream_reader_if #(.RAM_WIDTH(W), .ADDR_W(AW)) bus ();

  bram_stream_reader #(.RAM_WIDTH(W), .RAM_DEPTH(DEPTH), .READ_LATENCY(2), .FIFO_DEPTH(4)) dut (
    .clk_in(clk), .rst_in(rst), .start_in(start), .base_addr_in(base), .len_in(len),
    .busy_out(busy), .done_out(done), .bus(bus)
  );

  always #5 clk = ~clk;

  // RAM model: data[i] = i, address register then output register.
  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] r1 = '0, r2 = '0;
  initial for (int i = 0; i < DEPTH; i++) mem[i] = W'(i);
  always @(posedge clk) begin
    if (bus.ram_en_out) r1 <= mem[bus.ram_addr_out];
    if (bus.ram_regce_out) r2 <= r1;
  end
  assign bus.ram_data_in = r2;

  int checks = 0, errors = 0, cyc = 0;
  logic [W:0]    exp_q[$];
  logic [AW-1:0] addr_q[$];
  int first_valid_cyc, last_hs_cyc, done_cyc, done_cnt, hs_cnt;
  logic prev_stall = 0;
  logic [W:0] prev_word;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Negedge monitor: address order, stream order, stall stability, done pulses.
  always @(negedge clk) begin
    if (rst) prev_stall = 0;
    else begin
      if (bus.ram_en_out) begin
        if (addr_q.size() == 0) chk("extra_ram_en", 1, 0);
        else chk("ram_addr", 32'(bus.ram_addr_out), 32'(addr_q.pop_front()));
      end
      if (prev_stall) begin
        chk("stall_valid", 32'(bus.valid_out), 1);
        chk("stall_word", 32'({bus.last_out, bus.data_out}), 32'(prev_word));
      end
      if (bus.valid_out && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (bus.valid_out && bus.ready_in) begin
        hs_cnt++;
        if (exp_q.size() == 0) chk("extra_word", 1, 0);
        else chk("stream_word", 32'({bus.last_out, bus.data_out}), 32'(exp_q.pop_front()));
        if (bus.last_out) last_hs_cyc = cyc;
      end
      prev_stall = bus.valid_out && !bus.ready_in;
      prev_word  = {bus.last_out, bus.data_out};
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic push_exp(input int b, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({(i == n - 1), W'((b + i) % DEPTH)});
      addr_q.push_back(AW'((b + i) % DEPTH));
    end
    first_valid_cyc = -1; last_hs_cyc = -1; done_cyc = -1; done_cnt = 0; hs_cnt = 0;
  endtask

  typedef struct {
    int base; int len; bit rnd; int restart; int exp_first; int exp_span;
  } vec_t;
  vec_t tbl[6];

  task automatic run_xfer(input vec_t v);
    int start_cyc, n;
    push_exp(v.base, v.len);
    base = AW'(v.base); len = (AW+1)'(v.len); start = 1;
    @(posedge clk); #1;
    start = 0; start_cyc = cyc;
    base = AW'($urandom); len = (AW+1)'($urandom);
    chk("busy_after_start", 32'(busy), 1);
    n = 0;
    while (done_cnt == 0 && n < LIMIT) begin
      bus.ready_in = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start = (v.restart != 0 && n == v.restart);
      @(posedge clk); #1;
      n++;
    end
    start = 0; bus.ready_in = 1;
    repeat (4) @(posedge clk);
    #1;
    chk("no_timeout", 32'(n < LIMIT), 1);
    chk("done_count", done_cnt, 1);
    chk("word_count", hs_cnt, v.len);
    chk("words_left", exp_q.size(), 0);
    chk("addrs_left", addr_q.size(), 0);
    chk("busy_idle", 32'(busy), 0);
    chk("first_valid_lat", (first_valid_cyc < 0) ? -1 : first_valid_cyc - start_cyc, v.exp_first);
    if (v.len == 0) chk("done_lat_start", done_cyc - start_cyc, 0);
    else chk("done_lat_last", done_cyc - last_hs_cyc, 1);
    if (v.exp_span >= 0) chk("burst_span", last_hs_cyc - first_valid_cyc, v.exp_span);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_valid"}, 32'(bus.valid_out), 0);
    chk({tag, "_last"},  32'(bus.last_out), 0);
    chk({tag, "_data"},  32'(bus.data_out), 0);
    chk({tag, "_en"},    32'(bus.ram_en_out), 0);
    chk({tag, "_addr"},  32'(bus.ram_addr_out), 0);
    chk({tag, "_regce"}, 32'(bus.ram_regce_out), 1);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_done"},  32'(done), 0);
  endtask

  initial begin
    bus.ready_in = 1;
    first_valid_cyc = -1; last_hs_cyc = -1; done_cyc = -1; done_cnt = 0; hs_cnt = 0;
    //          base  len  rnd restart first span
    tbl[0] = '{  10,    5,  0,   0,     3,    4};
    tbl[1] = '{1022,    4,  0,   0,     3,    3};
    tbl[2] = '{ 300,   64,  1,   0,     3,   -1};
    tbl[3] = '{   5,    0,  0,   0,    -1,   -1};
    tbl[4] = '{ 100,    8,  0,   3,     3,    7};
    tbl[5] = '{1000,   40,  1,  10,     3,   -1};

    repeat (3) @(posedge clk);
    #1;
    chk_cleared("reset");
    rst = 0;
    @(posedge clk); #1;

    foreach (tbl[i]) run_xfer(tbl[i]);

    // Asynchronous reset with words in flight, then a clean transfer.
    push_exp(200, 6);
    base = 200; len = 6; start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (4) @(posedge clk);
    #3 rst = 1;
    #1 chk_cleared("midreset");
    chk("midreset_no_done", done_cnt, 0);
    exp_q.delete(); addr_q.delete();
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    run_xfer('{0, 2, 0, 0, 3, 1});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
